// File: rtl/vec_mem_seq.sv
// Vector load/store memory sequencer: splits a 256-bit register into LANES word beats and gathers them back.
// Optional feature macro: VMEM_STRIDE_EN (adds a captured stride input; default stride is 1).
module vec_mem_seq #(
    parameter int LANES  = 16,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [ADDR_W-1:0]       base_addr,
`ifdef VMEM_STRIDE_EN
    input  logic [ADDR_W-1:0]       stride,
`endif
    input  logic [LANES*WORD_W-1:0] st_data,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*WORD_W-1:0] ld_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [WORD_W-1:0]       mem_rdata
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          iss_cnt_q;
    logic [CNT_W-1:0]          ret_cnt_q;
    logic [ADDR_W-1:0]         stride_q;
    logic [LANES*WORD_W-1:0]   st_vec_q;
    logic                      busy_q;
    logic                      done_q;
    logic [LANES*WORD_W-1:0]   ld_data_q;
    logic                      mem_req_q;
    logic                      mem_we_q;
    logic [ADDR_W-1:0]         mem_addr_q;
    logic [WORD_W-1:0]         mem_wdata_q;

    logic [ADDR_W-1:0]         stride_in_s;
    logic                      beat_s;
    logic                      ret_s;
    logic                      last_beat_s;
    logic                      rets_done_s;
    logic [CNT_W-1:0]          ret_nxt_s;
    logic [IDX_W-1:0]          ret_idx_s;

`ifdef VMEM_STRIDE_EN
    assign stride_in_s = stride;
`else
    assign stride_in_s = ADDR_W'(1);
`endif

    // Beat acceptance, in-range load returns and completion conditions.
    always_comb begin
        beat_s      = mem_req_q && mem_gnt;
        ret_s       = mem_rvalid && !mem_we_q
                      && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                      && (ret_cnt_q < CNT_W'(LANES));
        ret_nxt_s   = ret_cnt_q + {{(CNT_W-1){1'b0}}, ret_s};
        last_beat_s = beat_s && (iss_cnt_q == CNT_W'(LANES - 1));
        rets_done_s = (ret_nxt_s == CNT_W'(LANES));
        ret_idx_s   = ret_cnt_q[IDX_W-1:0];
    end

    // Sequencer FSM with registered memory-side and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            iss_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            stride_q    <= '0;
            st_vec_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ld_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Returns overlap issue, so gathering is shared by ISSUE and DRAIN.
            if (ret_s) begin
                ld_data_q[ret_idx_s*WORD_W +: WORD_W] <= mem_rdata;
                ret_cnt_q                             <= ret_nxt_s;
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= base_addr;
                        mem_wdata_q <= st_data[WORD_W-1:0];
                        st_vec_q    <= st_data >> WORD_W;
                        stride_q    <= stride_in_s;
                        iss_cnt_q   <= '0;
                        ret_cnt_q   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (beat_s) begin
                        iss_cnt_q   <= iss_cnt_q + CNT_W'(1);
                        mem_addr_q  <= mem_addr_q + stride_q;
                        mem_wdata_q <= st_vec_q[WORD_W-1:0];
                        st_vec_q    <= st_vec_q >> WORD_W;
                    end
                    if (last_beat_s) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q || rets_done_s) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            mem_we_q <= 1'b0;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rets_done_s) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ld_data   = ld_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq: directed scenarios plus randomized transfers against a
// transaction-level model (lane list, word memory array, in-order return queue).
module tb_vec_mem_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
`ifdef VMEM_STRIDE_EN
    logic [15:0]  stride_s;
`endif
    logic [255:0] st_data;
    logic         busy;
    logic         done;
    logic [255:0] ld_data;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [15:0]  mem_rdata;

    int           cmp_cnt = 0;
    int           err_cnt = 0;
    logic [15:0]  mem [0:65535];
    logic [255:0] exp_ld;

    vec_mem_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
`ifdef VMEM_STRIDE_EN
        .stride     (stride_s),
`endif
        .st_data    (st_data),
        .busy       (busy),
        .done       (done),
        .ld_data    (ld_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        exp_ld = '0;
    endtask

    // One transfer: model tracks beats granted, returns delivered and the completion cycle.
    task automatic run_xfer(input bit st, input logic [15:0] base, input logic [15:0] strd,
                            input logic [255:0] data, input int gmode, input int lmode,
                            output int fin_out);
        int          c, beats, rets, fin, stall;
        bit          finished, gnt;
        logic [15:0] ea;
        int          rq_cyc[$];
        logic [15:0] rq_dat[$];
        beats = 0; rets = 0; fin = -1; stall = 0; finished = 1'b0; fin_out = -1;
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; st_data = data;
`ifdef VMEM_STRIDE_EN
        stride_s = strd;
`endif
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!finished && c < 400) begin
            ea = base + 16'(beats) * strd;
            chk("busy", busy, (fin == -1) || (c <= fin));
            chk("done", done, (fin != -1) && (c == fin + 1));
            if (beats < 16) begin
                chk("mem_req", mem_req, 1'b1);
                chk("mem_we", mem_we, st);
                chk("mem_addr", mem_addr, ea);
                if (st) chk("mem_wdata", mem_wdata, data[beats*16 +: 16]);
            end else begin
                chk("mem_req_low", mem_req, 1'b0);
            end
            if (fin != -1 && c == fin + 1) begin
                chk("ld_data_at_done", ld_data, exp_ld);
                start = 1'b1; is_store = 1'($urandom_range(0, 1)); base_addr = 16'($urandom);
                mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'($urandom);
                @(negedge clk);
                start = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
                chk("busy_after_done", busy, 1'b0);
                chk("req_after_done", mem_req, 1'b0);
                chk("ld_data_held", ld_data, exp_ld);
                fin_out  = c;
                finished = 1'b1;
            end else begin
                if (gmode == 0) begin
                    gnt = 1'b1;
                end else if (gmode == 1) begin
                    if ((beats == 3 || beats == 9) && stall < 2) begin
                        gnt = 1'b0; stall++;
                    end else begin
                        gnt = 1'b1; stall = 0;
                    end
                end else begin
                    gnt = ($urandom_range(0, 3) != 0);
                end
                mem_gnt = gnt;
                start   = ($urandom_range(0, 7) == 0);
                base_addr = 16'($urandom);
                if (gnt && beats < 16) begin
                    if (st) begin
                        mem[mem_addr] = mem_wdata;
                    end else begin
                        rq_cyc.push_back(c + ((lmode == 0) ? 1 : int'($urandom_range(1, 4))));
                        rq_dat.push_back(mem[mem_addr]);
                    end
                    beats++;
                    if (st && beats == 16) fin = c;
                end
                if (!st && rq_cyc.size() > 0 && rq_cyc[0] <= c) begin
                    void'(rq_cyc.pop_front());
                    mem_rvalid = 1'b1;
                    mem_rdata  = rq_dat.pop_front();
                    exp_ld[rets*16 +: 16] = mem_rdata;
                    rets++;
                end else begin
                    mem_rvalid = st ? ($urandom_range(0, 3) == 0) : 1'b0;
                    mem_rdata  = 16'($urandom);
                end
                if (!st && beats == 16 && rets == 16 && fin == -1) fin = c;
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        if (!finished) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL timeout: done not seen within %0d cycles (beats=%0d rets=%0d)", c, beats, rets);
        end
    endtask

    initial begin
        logic [255:0] vec;
        logic [15:0]  a, strd;
        int           fin;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3);
        is_store = 1'b0; base_addr = '0; st_data = '0; mem_rdata = '0;
`ifdef VMEM_STRIDE_EN
        stride_s = 16'd1;
`endif
        @(negedge clk);
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_ld", ld_data, 256'd0);

        // Store, grant tied high: done on cycle 17.
        for (int k = 0; k < 16; k++) vec[k*16 +: 16] = 16'h3C00 + 16'(k);
        run_xfer(1'b1, 16'h0100, 16'd1, vec, 0, 0, fin);
        chk("s1_done_cycle", 32'(fin), 32'd17);
        for (int k = 0; k < 16; k++) chk("s1_mem", mem[16'h0100 + 16'(k)], 16'h3C00 + 16'(k));

        // Load, 1-cycle latency: last return on cycle 17, done on 18.
        for (int k = 0; k < 16; k++) mem[16'h0200 + 16'(k)] = 16'h4000 | 16'(k);
        run_xfer(1'b0, 16'h0200, 16'd1, '0, 0, 0, fin);
        chk("s2_done_cycle", 32'(fin), 32'd18);
        for (int k = 0; k < 16; k++) chk("s2_lane", ld_data[k*16 +: 16], 16'h4000 | 16'(k));

        // Store with two 2-cycle stalls: four cycles later than the unstalled store.
        run_xfer(1'b1, 16'h0500, 16'd1, vec, 1, 0, fin);
        chk("s3_done_cycle", 32'(fin), 32'd21);
        for (int k = 0; k < 16; k += 5) chk("s3_mem", mem[16'h0500 + 16'(k)], 16'h3C00 + 16'(k));

        // Load wrapping through 0xFFFF -> 0x0000.
        for (int k = 0; k < 16; k++) begin
            a = 16'hFFF8 + 16'(k);
            mem[a] = 16'h7000 + 16'(k);
        end
        run_xfer(1'b0, 16'hFFF8, 16'd1, '0, 2, 1, fin);
        chk("s4_lane0", ld_data[15:0], 16'h7000);
        chk("s4_lane8", ld_data[143:128], 16'h7008);
        chk("s4_lane15", ld_data[255:240], 16'h700F);

        // Second start mid-store is ignored; reset at beat 5 aborts; stray return afterwards is dropped.
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0300; st_data = vec;
`ifdef VMEM_STRIDE_EN
        stride_s = 16'd1;
`endif
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            chk("s5_addr", mem_addr, 16'h0300 + 16'(c - 1));
            mem_gnt = 1'b1;
            start   = (c == 3);
            base_addr = 16'h0900;
            @(negedge clk);
        end
        start = 1'b0;
        chk("s5_addr_beat5", mem_addr, 16'h0305);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_gnt = 1'b0;
        exp_ld = '0;
        chk("s5_req", mem_req, 1'b0);
        chk("s5_busy", busy, 1'b0);
        chk("s5_done", done, 1'b0);
        chk("s5_addr_rst", mem_addr, 16'h0000);
        chk("s5_ld_rst", ld_data, 256'd0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("s5_ld_stray", ld_data, 256'd0);
        chk("s5_busy_stray", busy, 1'b0);

`ifdef VMEM_STRIDE_EN
        // Strided load: lane k at 0x0010 + 4k.
        for (int k = 0; k < 16; k++) mem[16'h0010 + 16'(4 * k)] = 16'h6100 + 16'(k);
        run_xfer(1'b0, 16'h0010, 16'd4, '0, 2, 1, fin);
        for (int k = 0; k < 16; k++) chk("s6_lane", ld_data[k*16 +: 16], 16'h6100 + 16'(k));
`endif

        // Randomized mix of loads and stores.
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < 8; w++) vec[w*32 +: 32] = $urandom;
            strd = 16'd1;
`ifdef VMEM_STRIDE_EN
            case ($urandom_range(0, 3))
                0:       strd = 16'd0;
                1:       strd = 16'($urandom);
                default: strd = 16'($urandom_range(1, 8));
            endcase
`endif
            run_xfer(1'($urandom_range(0, 1)), 16'($urandom), strd, vec,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), fin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
